// File: rtl/mpp_pkg.sv
// Shared definitions for the mpp program-memory responder: FSM states,
// the NOP opcode and the position of the fetch strobe in mpp out_signals.
package mpp_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_LOAD  = 2'd1,
      ST_READY = 2'd2
   } pm_state_e;

   localparam logic [7:0]  NOP_OPCODE       = 8'h00;
   localparam int unsigned FETCH_STROBE_BIT = 1;

endpackage : mpp_pkg

// File: rtl/prog_mem_responder_if.sv
// Fetch and byte-stream load bus between the mpp core/loader (master)
// and the program-memory responder (slave).
interface prog_mem_responder_if #(
   parameter int unsigned ADDR_W = 16
);

   logic              fetch_en;
   logic [ADDR_W-1:0] program_addr;
   logic [7:0]        instruction;
   logic              instr_valid;
   logic              addr_err;
   logic              load_start;
   logic              load_valid;
   logic [7:0]        load_data;
   logic              load_last;
   logic              load_ready;
   logic              load_done;
   logic [7:0]        checksum;

   modport master (
      output fetch_en, program_addr,
      output load_start, load_valid, load_data, load_last,
      input  instruction, instr_valid, addr_err,
      input  load_ready, load_done, checksum
   );

   modport slave (
      input  fetch_en, program_addr,
      input  load_start, load_valid, load_data, load_last,
      output instruction, instr_valid, addr_err,
      output load_ready, load_done, checksum
   );

endinterface : prog_mem_responder_if

// File: rtl/prog_mem_array.sv
// Byte RAM with one write port and one registered read port; contents and
// read register are deliberately not reset.
module prog_mem_array #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned IDX_W = 8
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [IDX_W-1:0] waddr_i,
   input  logic [7:0]       wdata_i,
   input  logic             re_i,
   input  logic [IDX_W-1:0] raddr_i,
   output logic [7:0]       rdata_o
);

   logic [7:0] mem_q [DEPTH];
   logic [7:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule : prog_mem_array

// File: rtl/prog_mem_responder.sv
// Program-memory responder for the mpp instruction-fetch bus: load FSM,
// load pointer and fetch qualification. Optional: PROG_MEM_CHECKSUM_EN.
module prog_mem_responder
   import mpp_pkg::*;
#(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned DEPTH     = 256,
   parameter logic [7:0]  NOP_INSTR = NOP_OPCODE
) (
   input logic                 clk,
   input logic                 rst,
   prog_mem_responder_if.slave bus
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0]    DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(DEPTH - 1);

   pm_state_e        state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             valid_q, valid_d;
   logic             src_mem_q, src_mem_d;

   logic             mem_we;
   logic             mem_re;
   logic [7:0]       mem_rdata;
   logic             in_range;

   // Extra top bit keeps the compare correct when DEPTH == 2**ADDR_W.
   assign in_range = ({1'b0, bus.program_addr} < DEPTH_EXT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_EMPTY;
         ptr_q     <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         valid_q   <= 1'b0;
         src_mem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         done_q    <= done_d;
         err_q     <= err_d;
         valid_q   <= valid_d;
         src_mem_q <= src_mem_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      done_d    = 1'b0;
      err_d     = err_q;
      valid_d   = 1'b0;
      src_mem_d = src_mem_q;
      mem_we    = 1'b0;
      mem_re    = 1'b0;

      if (bus.load_start) begin
         // load_start pre-empts any write or fetch in the same cycle.
         state_d = ST_LOAD;
         ptr_d   = '0;
         err_d   = 1'b0;
         if (bus.fetch_en) begin
            src_mem_d = 1'b0;
         end
      end else begin
         unique case (state_q)
            ST_LOAD: begin
               if (bus.load_valid) begin
                  mem_we = 1'b1;
                  ptr_d  = ptr_q + IDX_W'(1);
                  if (bus.load_last || (ptr_q == LAST_IDX)) begin
                     state_d = ST_READY;
                     done_d  = 1'b1;
                  end
               end
               if (bus.fetch_en) begin
                  src_mem_d = 1'b0;
               end
            end
            ST_READY: begin
               if (bus.fetch_en) begin
                  valid_d = 1'b1;
                  if (in_range) begin
                     mem_re    = 1'b1;
                     src_mem_d = 1'b1;
                  end else begin
                     src_mem_d = 1'b0;
                     err_d     = 1'b1;
                  end
               end
            end
            default: begin
               if (bus.fetch_en) begin
                  src_mem_d = 1'b0;
               end
            end
         endcase
      end
   end

   prog_mem_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (ptr_q),
      .wdata_i (bus.load_data),
      .re_i    (mem_re),
      .raddr_i (bus.program_addr[IDX_W-1:0]),
      .rdata_o (mem_rdata)
   );

`ifdef PROG_MEM_CHECKSUM_EN
   logic [7:0] csum_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csum_q <= '0;
      end else if (bus.load_start) begin
         csum_q <= '0;
      end else if ((state_q == ST_LOAD) && bus.load_valid) begin
         csum_q <= csum_q + bus.load_data;
      end
   end

   assign bus.checksum = csum_q;
`else
   assign bus.checksum = '0;
`endif

   // The read register only updates on served fetches, so it already holds
   // the last memory byte; src_mem_q selects it or the NOP constant.
   assign bus.instruction = src_mem_q ? mem_rdata : NOP_INSTR;
   assign bus.instr_valid = valid_q;
   assign bus.addr_err    = err_q;
   assign bus.load_ready  = (state_q == ST_LOAD);
   assign bus.load_done   = done_q;

endmodule : prog_mem_responder

// File: tb/tb_prog_mem_responder.sv
// Scoreboard bench for prog_mem_responder; expected checksum follows
// PROG_MEM_CHECKSUM_EN.
module tb_prog_mem_responder;
   import mpp_pkg::*;

   typedef struct packed {
      logic [7:0] instr;
      logic       valid;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] out_signals = '0;
   exp_t       sb[$];
   int         n_pass  = 0;
   int         n_total = 0;

   prog_mem_responder_if #(.ADDR_W(16)) bus ();

   assign bus.fetch_en = out_signals[FETCH_STROBE_BIT];

   prog_mem_responder #(
      .ADDR_W    (16),
      .DEPTH     (256),
      .NOP_INSTR (8'h00)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [15:0] a, input logic [7:0] ei, input logic ev);
      out_signals[FETCH_STROBE_BIT] = 1'b1;
      bus.program_addr = a;
      sb.push_back('{instr: ei, valid: ev});
      tick();
      out_signals[FETCH_STROBE_BIT] = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_instruction"}, bus.instruction, 8'h00);
      chk({tag, "_instr_valid"}, bus.instr_valid, 1'b0);
      chk({tag, "_addr_err"},    bus.addr_err, 1'b0);
      chk({tag, "_load_ready"},  bus.load_ready, 1'b0);
      chk({tag, "_load_done"},   bus.load_done, 1'b0);
      chk({tag, "_checksum"},    bus.checksum, 8'h00);
   endtask

   // Streams bytes while in LOAD; issue_start=0 means LOAD was already entered.
   task automatic do_load(input logic [7:0] data[$], input bit mark_last, input bit issue_start);
      logic [7:0] sum;
      logic [7:0] exp_sum;
      sum = 8'h00;
      if (issue_start) begin
         bus.load_start = 1'b1;
         tick();
         bus.load_start = 1'b0;
      end
      chk("load_ready_in_load", bus.load_ready, 1'b1);
      for (int i = 0; i < data.size(); i++) begin
         bus.load_valid = 1'b1;
         bus.load_data  = data[i];
         bus.load_last  = mark_last && (i == data.size() - 1);
         sum = sum + data[i];
         tick();
         if (i == data.size() - 1) begin
`ifdef PROG_MEM_CHECKSUM_EN
            exp_sum = sum;
`else
            exp_sum = 8'h00;
`endif
            chk("load_done_pulse", bus.load_done, 1'b1);
            chk("load_ready_after_done", bus.load_ready, 1'b0);
            chk("checksum_final", bus.checksum, exp_sum);
         end else if (i == 0 || i == data.size() - 2) begin
            chk("load_done_early", bus.load_done, 1'b0);
         end
      end
      bus.load_valid = 1'b0;
      bus.load_last  = 1'b0;
      tick();
      chk("load_done_single_cycle", bus.load_done, 1'b0);
   endtask

   // Monitor: every cycle either pops an expected fetch response or checks idle hold.
   initial begin : monitor
      logic [7:0] last_instr;
      logic       issued;
      exp_t       e;
      last_instr = 8'h00;
      forever begin
         @(posedge clk);
         if (rst) begin
            last_instr = 8'h00;
         end else begin
            issued = bus.fetch_en;
            #2;
            if (issued) begin
               if (sb.size() == 0) begin
                  n_total++;
                  $display("FAIL unexpected_fetch: got response with empty scoreboard at %0t", $time);
               end else begin
                  e = sb.pop_front();
                  chk("fetch_instr", bus.instruction, e.instr);
                  chk("fetch_valid", bus.instr_valid, e.valid);
                  last_instr = e.instr;
               end
            end else begin
               chk("idle_valid", bus.instr_valid, 1'b0);
               chk("idle_hold", bus.instruction, last_instr);
            end
         end
      end
   end

   initial begin : stim
      logic [7:0] prog[$];
      logic [7:0] big[$];
      bus.program_addr = '0;
      bus.load_start   = 1'b0;
      bus.load_valid   = 1'b0;
      bus.load_data    = '0;
      bus.load_last    = 1'b0;

      repeat (2) tick();
      check_reset_values("reset");
      rst = 1'b0;
      tick();

      // Fetch before any load: blocked.
      fetch(16'h0000, 8'h00, 1'b0);
      tick();

      prog = '{8'h07, 8'hC0, 8'h40, 8'hC1};
      do_load(prog, 1'b1, 1'b1);

      // Back-to-back fetches, then hold.
      fetch(16'h0000, 8'h07, 1'b1);
      fetch(16'h0001, 8'hC0, 1'b1);
      fetch(16'h0002, 8'h40, 1'b1);
      fetch(16'h0003, 8'hC1, 1'b1);
      tick();
      tick();

      // Out-of-range fetch and sticky error.
      chk("addr_err_before", bus.addr_err, 1'b0);
      fetch(16'h0100, 8'h00, 1'b1);
      chk("addr_err_set", bus.addr_err, 1'b1);
      fetch(16'h0002, 8'h40, 1'b1);
      chk("addr_err_sticky", bus.addr_err, 1'b1);
      tick();

      // load_start beats a concurrent fetch and clears addr_err.
      bus.load_start = 1'b1;
      out_signals[FETCH_STROBE_BIT] = 1'b1;
      bus.program_addr = 16'h0001;
      sb.push_back('{instr: 8'h00, valid: 1'b0});
      tick();
      bus.load_start = 1'b0;
      out_signals[FETCH_STROBE_BIT] = 1'b0;
      chk("addr_err_cleared", bus.addr_err, 1'b0);

      // Auto-terminate after 256 bytes without load_last.
      for (int i = 0; i < 256; i++) begin
         big.push_back(8'(i) ^ 8'h5A);
      end
      do_load(big, 1'b0, 1'b0);
      fetch(16'h00FF, 8'hA5, 1'b1);
      fetch(16'h0080, 8'hDA, 1'b1);
      fetch(16'h01FF, 8'h00, 1'b1);
      chk("addr_err_upper_bits", bus.addr_err, 1'b1);
      fetch(16'h0000, 8'h5A, 1'b1);
      tick();

      // Reset asserted asynchronously mid-load.
      bus.load_start = 1'b1;
      tick();
      bus.load_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.load_valid = 1'b1;
         bus.load_data  = 8'h30 + 8'(i);
         tick();
      end
      #3;
      rst = 1'b1;
      #1;
      check_reset_values("async_reset");
      bus.load_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      fetch(16'h0000, 8'h00, 1'b0);
      tick();

      prog = '{8'h11, 8'h22};
      do_load(prog, 1'b1, 1'b1);
      fetch(16'h0001, 8'h22, 1'b1);
      fetch(16'h0000, 8'h11, 1'b1);
      tick();

      for (int k = 0; k < 10 && sb.size() != 0; k++) begin
         tick();
      end
      if (sb.size() != 0) begin
         chk("scoreboard_drain", sb.size(), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_prog_mem_responder
